cache_repl_unit: RTL and testbench

- Parametrised per-set replacement-state block for the I- and D-caches; generalises the counter-based LRU to selectable policies.
- Holds replacement state for every set and returns a registered victim way on request.
- Victim selection prefers invalid ways and skips locked ways.
- Tracks touches (hit/fill) and invalidations; instantiated next to cache tag arrays.

---
 rtl/cache_repl_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_cache_repl_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_repl_unit.sv
// Per-set replacement state (true LRU by age permutation, or tree pseudo-LRU) with a registered victim lookup.
// Define CACHE_REPL_LOCK_EN to add the per-way victim_lock_mask input and the victim_none flag.

module cache_repl_set #(
    parameter int WAYS    = 4,
    parameter int WAYS_W  = 2,
    parameter int POLICY  = 0,
    parameter int STATE_W = (POLICY == 0) ? WAYS * WAYS_W : WAYS - 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               upd_en,
    input  logic [WAYS_W-1:0]  upd_way,
    input  logic               inv_en,
    input  logic [WAYS_W-1:0]  inv_way,
    output logic [STATE_W-1:0] state
);

    generate
        if (POLICY == 0) begin : g_age
            logic [WAYS-1:0][WAYS_W-1:0] age_q, age_mid, age_d;

            // Invalidate is applied first so a same-cycle touch always wins.
            always_comb begin
                age_mid = age_q;
                if (inv_en) begin
                    for (int v = 0; v < WAYS; v++)
                        if (age_q[v] > age_q[inv_way]) age_mid[v] = age_q[v] - 1'b1;
                    age_mid[inv_way] = WAYS_W'(WAYS - 1);
                end
                age_d = age_mid;
                if (upd_en) begin
                    for (int v = 0; v < WAYS; v++)
                        if (age_mid[v] < age_mid[upd_way]) age_d[v] = age_mid[v] + 1'b1;
                    age_d[upd_way] = '0;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int w = 0; w < WAYS; w++) age_q[w] <= WAYS_W'(WAYS - 1 - w);
                end else begin
                    age_q <= age_d;
                end
            end

            assign state = age_q;
        end else begin : g_tree
            // Heap-ordered node bits: node n has children 2n+1 (bit=0) and 2n+2 (bit=1).
            logic [WAYS-2:0] tree_q, tree_mid, tree_d;

            always_comb begin
                tree_mid = tree_q;
                if (inv_en)
                    for (int l = 0; l < WAYS_W; l++)
                        for (int k = 0; k < (1 << l); k++)
                            if (int'(inv_way >> (WAYS_W - l)) == k)
                                tree_mid[(1 << l) - 1 + k] = inv_way[WAYS_W-1-l];
                tree_d = tree_mid;
                if (upd_en)
                    for (int l = 0; l < WAYS_W; l++)
                        for (int k = 0; k < (1 << l); k++)
                            if (int'(upd_way >> (WAYS_W - l)) == k)
                                tree_d[(1 << l) - 1 + k] = ~upd_way[WAYS_W-1-l];
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) tree_q <= '0;
                else        tree_q <= tree_d;
            end

            assign state = tree_q;
        end
    endgenerate

endmodule

module cache_repl_unit #(
    parameter int NUM_SET        = 64,
    parameter int WAYS_PER_SET   = 4,
    parameter int POLICY         = 0,
    parameter int NUM_SET_W      = $clog2(NUM_SET),
    parameter int WAYS_PER_SET_W = $clog2(WAYS_PER_SET)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      victim_req,
    input  logic [NUM_SET_W-1:0]      victim_set,
    input  logic [WAYS_PER_SET-1:0]   victim_valid_mask,
`ifdef CACHE_REPL_LOCK_EN
    input  logic [WAYS_PER_SET-1:0]   victim_lock_mask,
`endif
    output logic                      victim_valid,
    output logic [WAYS_PER_SET_W-1:0] victim_way,
    output logic                      victim_none,
    input  logic                      update_req,
    input  logic [NUM_SET_W-1:0]      update_set,
    input  logic [WAYS_PER_SET_W-1:0] update_way,
    input  logic                      inval_req,
    input  logic [NUM_SET_W-1:0]      inval_set,
    input  logic [WAYS_PER_SET_W-1:0] inval_way
);

    localparam int WAYS    = WAYS_PER_SET;
    localparam int W       = WAYS_PER_SET_W;
    localparam int STATE_W = (POLICY == 0) ? WAYS * W : WAYS - 1;

    logic [NUM_SET-1:0][STATE_W-1:0] set_state;
    logic [STATE_W-1:0]              sel_state;
    logic                            inv_hit;
    logic [W-1:0]                    inv_sel;
    logic [W-1:0]                    pol_way;
    logic                            valid_q;
    logic [W-1:0]                    way_q;
`ifdef CACHE_REPL_LOCK_EN
    logic                            pol_none;
    logic                            none_q;
`endif

    generate
        for (genvar s = 0; s < NUM_SET; s++) begin : g_set
            cache_repl_set #(
                .WAYS   (WAYS),
                .WAYS_W (W),
                .POLICY (POLICY)
            ) u_set (
                .clock   (clock),
                .reset   (reset),
                .upd_en  (update_req && (update_set == NUM_SET_W'(s))),
                .upd_way (update_way),
                .inv_en  (inval_req && (inval_set == NUM_SET_W'(s))),
                .inv_way (inval_way),
                .state   (set_state[s])
            );
        end
    endgenerate

    // Registered state only: a same-cycle update/inval is not visible to this lookup.
    assign sel_state = set_state[victim_set];

    always_comb begin
        inv_hit = 1'b0;
        inv_sel = '0;
        for (int v = WAYS - 1; v >= 0; v--)
            if (!victim_valid_mask[v]) begin
                inv_hit = 1'b1;
                inv_sel = W'(v);
            end
    end

    generate
        if (POLICY == 0) begin : g_lru_pick
            logic [WAYS-1:0][W-1:0] age;
            logic [W-1:0]           best;
            assign age = sel_state;

            always_comb begin
                pol_way = '0;
                best    = '0;
`ifdef CACHE_REPL_LOCK_EN
                pol_none = 1'b1;
                for (int v = 0; v < WAYS; v++)
                    if (!victim_lock_mask[v] && (pol_none || age[v] > best)) begin
                        pol_none = 1'b0;
                        best     = age[v];
                        pol_way  = W'(v);
                    end
`else
                for (int v = 0; v < WAYS; v++)
                    if (age[v] >= best) begin
                        best    = age[v];
                        pol_way = W'(v);
                    end
`endif
            end
        end else begin : g_plru_pick
            logic [W-1:0] ptr;

            // Resolve the pointed leaf MSB-first; each level picks the node named by the bits so far.
            always_comb begin
                ptr = '0;
                for (int l = 0; l < W; l++)
                    for (int k = 0; k < (1 << l); k++)
                        if (int'(ptr >> (W - l)) == k)
                            ptr[W-1-l] = sel_state[(1 << l) - 1 + k];
                pol_way = ptr;
`ifdef CACHE_REPL_LOCK_EN
                pol_none = &victim_lock_mask;
                if (victim_lock_mask[ptr]) begin
                    pol_way = '0;
                    for (int v = WAYS - 1; v >= 0; v--)
                        if (!victim_lock_mask[v]) pol_way = W'(v);
                end
`endif
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            way_q   <= '0;
`ifdef CACHE_REPL_LOCK_EN
            none_q  <= 1'b0;
`endif
        end else begin
            valid_q <= victim_req;
            if (victim_req) begin
                way_q  <= inv_hit ? inv_sel : pol_way;
`ifdef CACHE_REPL_LOCK_EN
                none_q <= !inv_hit && pol_none;
`endif
            end
        end
    end

    assign victim_valid = valid_q;
    assign victim_way   = way_q;
`ifdef CACHE_REPL_LOCK_EN
    assign victim_none  = none_q;
`else
    assign victim_none  = 1'b0;
`endif

endmodule

// File: tb/tb_cache_repl_unit.sv
// Directed bench: one true-LRU and one tree-PLRU instance driven by shared stimulus.
module tb_cache_repl_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       victim_req = 1'b0;
    logic [5:0] victim_set = '0;
    logic [3:0] victim_valid_mask = 4'hF;
    logic       update_req = 1'b0;
    logic [5:0] update_set = '0;
    logic [1:0] update_way = '0;
    logic       inval_req = 1'b0;
    logic [5:0] inval_set = '0;
    logic [1:0] inval_way = '0;
`ifdef CACHE_REPL_LOCK_EN
    logic [3:0] victim_lock_mask = 4'h0;
`endif

    logic       v0_valid, v0_none, v1_valid, v1_none;
    logic [1:0] v0_way, v1_way;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cache_repl_unit #(.NUM_SET(64), .WAYS_PER_SET(4), .POLICY(0)) dut0 (
        .clock(clock), .reset(reset),
        .victim_req(victim_req), .victim_set(victim_set), .victim_valid_mask(victim_valid_mask),
`ifdef CACHE_REPL_LOCK_EN
        .victim_lock_mask(victim_lock_mask),
`endif
        .victim_valid(v0_valid), .victim_way(v0_way), .victim_none(v0_none),
        .update_req(update_req), .update_set(update_set), .update_way(update_way),
        .inval_req(inval_req), .inval_set(inval_set), .inval_way(inval_way)
    );

    cache_repl_unit #(.NUM_SET(64), .WAYS_PER_SET(4), .POLICY(1)) dut1 (
        .clock(clock), .reset(reset),
        .victim_req(victim_req), .victim_set(victim_set), .victim_valid_mask(victim_valid_mask),
`ifdef CACHE_REPL_LOCK_EN
        .victim_lock_mask(victim_lock_mask),
`endif
        .victim_valid(v1_valid), .victim_way(v1_way), .victim_none(v1_none),
        .update_req(update_req), .update_set(update_set), .update_way(update_way),
        .inval_req(inval_req), .inval_set(inval_set), .inval_way(inval_way)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic vic(input logic [5:0] s, input logic [3:0] m);
        victim_req = 1'b1;
        victim_set = s;
        victim_valid_mask = m;
        cyc();
        victim_req = 1'b0;
        victim_valid_mask = 4'hF;
    endtask

    task automatic touch(input logic [5:0] s, input logic [1:0] w);
        update_req = 1'b1;
        update_set = s;
        update_way = w;
        cyc();
        update_req = 1'b0;
    endtask

    task automatic inval(input logic [5:0] s, input logic [1:0] w);
        inval_req = 1'b1;
        inval_set = s;
        inval_way = w;
        cyc();
        inval_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state
        cyc();
        check("rst_valid", v0_valid, 1'b0);
        check("rst_way",   v0_way,   2'd0);
        check("rst_none",  v0_none,  1'b0);
        reset = 1'b1;
        cyc();

        // First lookup after reset, then pulse drop
        vic(6'd3, 4'hF);
        check("first_valid", v0_valid, 1'b1);
        check("first_way",   v0_way,   2'd0);
        check("first_none",  v0_none,  1'b0);
        check("plru_first_way", v1_way, 2'd0);
        cyc();
        check("pulse_drop", v0_valid, 1'b0);

        // LRU: touch 0..3 in set 5 -> ages back to [3,2,1,0]
        for (int w = 0; w < 4; w++) touch(6'd5, 2'(w));
        vic(6'd5, 4'hF);
        check("lru_after_sweep", v0_way, 2'd0);
        touch(6'd5, 2'd0);
        vic(6'd5, 4'hF);
        check("lru_after_touch0", v0_way, 2'd1);
        vic(6'd6, 4'hF);
        check("lru_other_set", v0_way, 2'd0);

        // Invalid way has priority; inval moves way to LRU
        vic(6'd5, 4'b1011);
        check("invalid_prio", v0_way, 2'd2);
        inval(6'd5, 2'd3);
        vic(6'd5, 4'hF);
        check("lru_inval3", v0_way, 2'd3);

        // Same-cycle touch and lookup: lookup sees pre-update state
        update_req = 1'b1; update_set = 6'd5; update_way = 2'd3;
        vic(6'd5, 4'hF);
        update_req = 1'b0;
        check("pre_update_read", v0_way, 2'd3);
        vic(6'd5, 4'hF);
        check("post_update_read", v0_way, 2'd1);

        // Same-set inval+update on one way nets to a touch: ages [2,0,3,1]
        update_req = 1'b1; update_set = 6'd5; update_way = 2'd1;
        inval_req  = 1'b1; inval_set  = 6'd5; inval_way  = 2'd1;
        cyc();
        update_req = 1'b0; inval_req = 1'b0;
        vic(6'd5, 4'hF);
        check("inval_update_same_way", v0_way, 2'd2);

        // Different sets in the same cycle
        update_req = 1'b1; update_set = 6'd7; update_way = 2'd0;
        inval_req  = 1'b1; inval_set  = 6'd8; inval_way  = 2'd3;
        cyc();
        update_req = 1'b0; inval_req = 1'b0;
        vic(6'd7, 4'hF);
        check("indep_set7", v0_way, 2'd1);
        vic(6'd8, 4'hF);
        check("indep_set8", v0_way, 2'd3);

        // Tree PLRU sequence on set 1
        do_reset();
        touch(6'd1, 2'd0);
        vic(6'd1, 4'hF);
        check("plru_touch0", v1_way, 2'd2);
        touch(6'd1, 2'd2);
        vic(6'd1, 4'hF);
        check("plru_touch2", v1_way, 2'd1);
        inval(6'd1, 2'd3);
        vic(6'd1, 4'hF);
        check("plru_inval3", v1_way, 2'd3);
        vic(6'd1, 4'b1101);
        check("plru_invalid_prio", v1_way, 2'd1);
        check("lru_invalid_prio",  v0_way, 2'd1);

`ifdef CACHE_REPL_LOCK_EN
        do_reset();
        victim_lock_mask = 4'b0001;
        vic(6'd2, 4'hF);
        check("lock0_lru_way",  v0_way,  2'd1);
        check("lock0_lru_none", v0_none, 1'b0);
        check("lock0_plru_way", v1_way,  2'd1);
        victim_lock_mask = 4'b1111;
        vic(6'd2, 4'hF);
        check("lockall_none", v0_none, 1'b1);
        check("lockall_way",  v0_way,  2'd0);
        check("lockall_plru_none", v1_none, 1'b1);
        vic(6'd2, 4'b1110);
        check("lockall_invalid_way",  v0_way,  2'd0);
        check("lockall_invalid_none", v0_none, 1'b0);
        victim_lock_mask = 4'b0000;
`endif

        // Reset during an outstanding result clears valid and state
        touch(6'd5, 2'd0);
        vic(6'd5, 4'hF);
        check("pre_reset_valid", v0_valid, 1'b1);
        check("pre_reset_way",   v0_way,   2'd1);
        reset = 1'b0;
        #1;
        check("async_reset_valid", v0_valid, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();
        vic(6'd5, 4'hF);
        check("post_reset_way", v0_way, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
